regfile_wb_arbiter: RTL and testbench

Arbitrates the single write port of the register file between two writeback requesters: channel A (ALU result) and channel B (load/multi-cycle unit result). Each channel uses a valid/ready handshake. The winning write is registered and drives the register file's `regWrite`/`writeAddr`/`writeData` one cycle later. The block also keeps a 32-bit pending-write scoreboard, which the issue stage uses to detect read-after-write hazards on in-flight registers.

---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register file write port between two
// writeback channels (A = ALU, B = load/multi-cycle unit). It registers the
// winning write and keeps a pending-write scoreboard for hazard detection.
//
// Optional feature macro: WB_ARB_RR_EN
//   defined   -> round-robin on contention (alternates A/B via last_grant)
//   undefined -> fixed priority, A always wins contention
module regfile_wb_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            valid_a,
    input  logic [AW-1:0]   addr_a,
    input  logic [DW-1:0]   data_a,
    output logic            ready_a,
    input  logic            valid_b,
    input  logic [AW-1:0]   addr_b,
    input  logic [DW-1:0]   data_b,
    output logic            ready_b,
    input  logic            reserve_valid,
    input  logic [AW-1:0]   reserve_addr,
    output logic            regWrite,
    output logic [AW-1:0]   writeAddr,
    output logic [DW-1:0]   writeData,
    output logic [NREG-1:0] pending
);

    typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} chan_t;

    chan_t          last_grant_reg;
    chan_t          last_grant_next;
    logic           grant_a;
    logic           grant_b;
    logic           xfer;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic           sel_in_range;
    logic           wr_ok;
    logic           reg_write_reg;
    logic [AW-1:0]  write_addr_reg;
    logic [DW-1:0]  write_data_reg;

    // Grant selection; reset (active low) and stall both suppress every grant.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst && !stall) begin
            if (valid_a && valid_b) begin
`ifdef WB_ARB_RR_EN
                if (last_grant_reg == CH_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
`else
                grant_a = 1'b1;
`endif
            end else if (valid_a) begin
                grant_a = 1'b1;
            end else if (valid_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign ready_a = grant_a;
    assign ready_b = grant_b;
    assign xfer    = grant_a | grant_b;

    // Mux the granted channel and decide whether it actually writes.
    always_comb begin
        sel_addr = grant_a ? addr_a : addr_b;
        sel_data = grant_a ? data_a : data_b;
        // Addresses beyond the register file are accepted but dropped.
        sel_in_range = (32'(sel_addr) < NREG);
        wr_ok = xfer && (sel_addr != '0) && sel_in_range;
    end

    // Pointer follows actual transfers only.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (grant_a) begin
            last_grant_next = CH_A;
        end else if (grant_b) begin
            last_grant_next = CH_B;
        end
    end

    // Last-grant register; resets to B so A wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_reg <= CH_B;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    // Write register: one-cycle regWrite pulse, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_reg  <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
        end else begin
            reg_write_reg <= wr_ok;
            if (wr_ok) begin
                write_addr_reg <= sel_addr;
                write_data_reg <= sel_data;
            end
        end
    end

    assign regWrite  = reg_write_reg;
    assign writeAddr = write_addr_reg;
    assign writeData = write_data_reg;

    // Scoreboard, one flop per register; register 0 is never pending.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending[gi] = 1'b0;
            end else begin : g_bit
                logic bit_reg;
                // Set by reserve, cleared by a write; set wins a same-cycle collision.
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        bit_reg <= 1'b0;
                    end else if (reserve_valid && (32'(reserve_addr) == gi)) begin
                        bit_reg <= 1'b1;
                    end else if (wr_ok && (32'(sel_addr) == gi)) begin
                        bit_reg <= 1'b0;
                    end
                end
                assign pending[gi] = bit_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Expectations follow the build
// configuration (WB_ARB_RR_EN selects round-robin contention results).
module tb_regfile_wb_arbiter;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            valid_a;
    logic [AW-1:0]   addr_a;
    logic [DW-1:0]   data_a;
    logic            ready_a;
    logic            valid_b;
    logic [AW-1:0]   addr_b;
    logic [DW-1:0]   data_b;
    logic            ready_b;
    logic            reserve_valid;
    logic [AW-1:0]   reserve_addr;
    logic            regWrite;
    logic [AW-1:0]   writeAddr;
    logic [DW-1:0]   writeData;
    logic [NREG-1:0] pending;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .valid_a(valid_a), .addr_a(addr_a), .data_a(data_a), .ready_a(ready_a),
        .valid_b(valid_b), .addr_b(addr_b), .data_b(data_b), .ready_b(ready_b),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [3:0] a_wins;
        int         na;
        int         nb;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;

`ifdef WB_ARB_RR_EN
        a_wins = 4'b0101;   // cycle 0 in bit 0: A,B,A,B
`else
        a_wins = 4'b1111;   // A,A,A,A
`endif

        // Reset with both channels requesting.
        rst = 1'b0; stall = 1'b0;
        valid_a = 1'b1; addr_a = 5'd3; data_a = 32'h1111_0003;
        valid_b = 1'b1; addr_b = 5'd4; data_b = 32'h2222_0004;
        reserve_valid = 1'b0; reserve_addr = '0;
        #1;
        check("rst_ready_a", ready_a, 0);
        check("rst_ready_b", ready_b, 0);
        tick();
        tick();
        check("rst_regWrite", regWrite, 0);
        check("rst_writeAddr", writeAddr, 0);
        check("rst_writeData", writeData, 0);
        check("rst_pending", pending, 0);
        check("rst_ready_a_held", ready_a, 0);
        check("rst_ready_b_held", ready_b, 0);
        $display("[TB] reset held 2 cycles with both valids");

        // Release: first contention goes to A.
        rst = 1'b1;
        #1;
        check("first_cont_ready_a", ready_a, 1);
        check("first_cont_ready_b", ready_b, 0);
        tick();
        check("first_cont_regWrite", regWrite, 1);
        check("first_cont_writeAddr", writeAddr, 3);
        check("first_cont_writeData", writeData, 32'h1111_0003);
        $display("[TB] first contention -> A, r3");

        // Reserve r5 (B is dropped now; it had not yet transferred).
        valid_a = 1'b0; valid_b = 1'b0;
        reserve_valid = 1'b1; reserve_addr = 5'd5;
        tick();
        check("resv5_pending", pending, 32'h0000_0020);
        check("resv5_regWrite", regWrite, 0);
        $display("[TB] reserve r5");

        // Single write A -> r5 clears the scoreboard bit.
        reserve_valid = 1'b0;
        valid_a = 1'b1; addr_a = 5'd5; data_a = 32'hDEAD_BEEF;
        #1;
        check("wr5_ready_a", ready_a, 1);
        tick();
        check("wr5_regWrite", regWrite, 1);
        check("wr5_writeAddr", writeAddr, 5);
        check("wr5_writeData", writeData, 32'hDEAD_BEEF);
        check("wr5_pending", pending, 0);
        $display("[TB] write A r5 = deadbeef");

        // Lone B write so last_grant = B before the contention run.
        valid_a = 1'b0;
        valid_b = 1'b1; addr_b = 5'd6; data_b = 32'h0000_0066;
        #1;
        check("wr6_ready_b", ready_b, 1);
        check("wr6_ready_a", ready_a, 0);
        tick();
        check("wr6_regWrite", regWrite, 1);
        check("wr6_writeAddr", writeAddr, 6);
        $display("[TB] write B r6 = 66");

        // Four cycles of contention; each side presents fresh data after a win.
        na = 0; nb = 0;
        valid_a = 1'b1; addr_a = 5'd8;
        valid_b = 1'b1; addr_b = 5'd9;
        for (int i = 0; i < 4; i++) begin
            data_a = 32'hAAAA_0000 + DW'(na);
            data_b = 32'hBBBB_0000 + DW'(nb);
            #1;
            check($sformatf("cont%0d_ready_a", i), ready_a, a_wins[i]);
            check($sformatf("cont%0d_ready_b", i), ready_b, !a_wins[i]);
            if (a_wins[i]) begin
                exp_addr = 5'd8; exp_data = 32'hAAAA_0000 + DW'(na); na++;
            end else begin
                exp_addr = 5'd9; exp_data = 32'hBBBB_0000 + DW'(nb); nb++;
            end
            tick();
            check($sformatf("cont%0d_regWrite", i), regWrite, 1);
            check($sformatf("cont%0d_writeAddr", i), writeAddr, exp_addr);
            check($sformatf("cont%0d_writeData", i), writeData, exp_data);
            $display("[TB] contention cycle %0d -> %s", i, a_wins[i] ? "A" : "B");
        end

        // Register 0 write: accepted, no regWrite, scoreboard untouched.
        valid_a = 1'b0;
        valid_b = 1'b1; addr_b = 5'd0; data_b = 32'h0000_1234;
        #1;
        check("r0_ready_b", ready_b, 1);
        tick();
        check("r0_regWrite", regWrite, 0);
        check("r0_pending", pending, 0);
        $display("[TB] write B r0 dropped");

        // Set/clear collision on r7.
        valid_b = 1'b0;
        reserve_valid = 1'b1; reserve_addr = 5'd7;
        tick();
        check("resv7_pending", pending, 32'h0000_0080);
        valid_a = 1'b1; addr_a = 5'd7; data_a = 32'h0000_0077;
        #1;
        check("coll_ready_a", ready_a, 1);
        tick();
        check("coll_regWrite", regWrite, 1);
        check("coll_writeAddr", writeAddr, 7);
        check("coll_pending", pending, 32'h0000_0080);
        $display("[TB] collision r7: set wins");

        // Stall blocks the grant.
        reserve_valid = 1'b0;
        stall = 1'b1; valid_a = 1'b1; addr_a = 5'd9; data_a = 32'h0000_0099;
        #1;
        check("stall_ready_a", ready_a, 0);
        check("stall_ready_b", ready_b, 0);
        tick();
        check("stall_regWrite", regWrite, 0);
        $display("[TB] stall blocks A");

        // Reset in the cycle A would be granted: no write follows.
        stall = 1'b0; rst = 1'b0;
        #1;
        check("midrst_ready_a", ready_a, 0);
        tick();
        rst = 1'b1; valid_a = 1'b0;
        check("midrst_regWrite", regWrite, 0);
        check("midrst_pending", pending, 0);
        tick();
        check("midrst_regWrite_after", regWrite, 0);
        $display("[TB] reset mid-operation discards grant");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
